// File: rtl/dither_pkg.sv
// dither_pkg: shared parser state, sync byte and pixel beat type for the SPI frame path
package dither_pkg;
  typedef enum logic [2:0] {IDLE, HDR_WH, HDR_WL, HDR_HH, HDR_HL, PIXELS, CHECK, ERROR} parser_state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  typedef struct packed {
    logic [7:0]  data;
    logic [15:0] x;
    logic [15:0] y;
    logic        eol;
    logic        eof;
  } pixel_beat_t;
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous first-word fall-through FIFO, active-low sync reset; a push while full is accepted only alongside a pop
module pixel_fifo #(
  parameter int  DEPTH = 16,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW:0] wp, rp;
  logic wr, rd;
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign dout  = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (wr) mem[wp[AW-1:0]] <= din;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/spi_frame_parser.sv
// spi_frame_parser: parses sync/W/H header and raster pixel bytes into a FIFO of coordinate-tagged beats.
// Optional trailer checksum byte with err_checksum output when SPI_FRAME_CHECKSUM_EN is defined.
module spi_frame_parser #(
  parameter int MAX_W      = 640,
  parameter int MAX_H      = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        cs_active,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_data,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic        frame_busy,
  output logic        err_header,
  output logic        err_overflow,
`ifdef SPI_FRAME_CHECKSUM_EN
  output logic        err_checksum,
`endif
  output logic        err_trunc
);
  import dither_pkg::*;
  parser_state_t state, state_n;
  logic [15:0] w, h, x, y, w_n, h_n, x_n, y_n, h_new;
  logic eh_n, eo_n, et_n, push, pop, fifo_full, fifo_empty, last_col, last_row, bad_hdr;
  pixel_beat_t beat, head;
`ifdef SPI_FRAME_CHECKSUM_EN
  logic [7:0] csum, csum_n;
  logic ec_n;
`endif
  assign last_col   = x == w - 16'd1;
  assign last_row   = y == h - 16'd1;
  assign beat       = '{data: byte_data, x: x, y: y, eol: last_col, eof: last_col && last_row};
  assign h_new      = {h[15:8], byte_data};
  assign bad_hdr    = w == '0 || w > 16'(MAX_W) || h_new == '0 || h_new > 16'(MAX_H);
  assign pix_valid  = !fifo_empty;
  assign pop        = pix_valid && pix_ready;
  assign pix_data   = pix_valid ? head.data : '0;
  assign pix_x      = pix_valid ? head.x : '0;
  assign pix_y      = pix_valid ? head.y : '0;
  assign pix_eol    = pix_valid && head.eol;
  assign pix_eof    = pix_valid && head.eof;
  assign frame_busy = state != IDLE;
  always_comb begin
    state_n = state;
    w_n     = w;
    h_n     = h;
    x_n     = x;
    y_n     = y;
    eh_n    = err_header;
    eo_n    = err_overflow;
    et_n    = err_trunc;
    push    = 1'b0;
`ifdef SPI_FRAME_CHECKSUM_EN
    csum_n  = csum;
    ec_n    = err_checksum;
`endif
    case (state)
      IDLE: if (byte_valid && cs_active) begin
        state_n = byte_data == SYNC_BYTE ? HDR_WH : ERROR;
        eh_n    = byte_data != SYNC_BYTE;
        eo_n    = byte_data != SYNC_BYTE && err_overflow;
        et_n    = byte_data != SYNC_BYTE && err_trunc;
`ifdef SPI_FRAME_CHECKSUM_EN
        ec_n    = byte_data != SYNC_BYTE && err_checksum;
`endif
      end
      ERROR: if (!cs_active) state_n = IDLE;
      default: if (!cs_active) begin
        state_n = IDLE;
        et_n    = 1'b1;
      end else if (byte_valid) begin
        case (state)
          HDR_WH: begin
            w_n[15:8] = byte_data;
            state_n   = HDR_WL;
          end
          HDR_WL: begin
            w_n[7:0] = byte_data;
            state_n  = HDR_HH;
          end
          HDR_HH: begin
            h_n[15:8] = byte_data;
            state_n   = HDR_HL;
          end
          HDR_HL: begin
            h_n     = h_new;
            eh_n    = bad_hdr;
            state_n = bad_hdr ? ERROR : PIXELS;
            x_n     = '0;
            y_n     = '0;
`ifdef SPI_FRAME_CHECKSUM_EN
            csum_n  = '0;
`endif
          end
          PIXELS: begin
            // a dropped byte still advances x/y so later coordinates stay aligned
            push = 1'b1;
            eo_n = err_overflow || (fifo_full && !pop);
            x_n  = last_col ? '0 : x + 16'd1;
            y_n  = last_col ? y + 16'd1 : y;
`ifdef SPI_FRAME_CHECKSUM_EN
            csum_n = csum ^ byte_data;
            if (beat.eof) state_n = CHECK;
`else
            if (beat.eof) state_n = IDLE;
`endif
          end
`ifdef SPI_FRAME_CHECKSUM_EN
          CHECK: begin
            ec_n    = err_checksum || byte_data != csum;
            state_n = IDLE;
          end
`endif
          default: state_n = state;
        endcase
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      w            <= '0;
      h            <= '0;
      x            <= '0;
      y            <= '0;
      err_header   <= 1'b0;
      err_overflow <= 1'b0;
      err_trunc    <= 1'b0;
`ifdef SPI_FRAME_CHECKSUM_EN
      csum         <= '0;
      err_checksum <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      w            <= w_n;
      h            <= h_n;
      x            <= x_n;
      y            <= y_n;
      err_header   <= eh_n;
      err_overflow <= eo_n;
      err_trunc    <= et_n;
`ifdef SPI_FRAME_CHECKSUM_EN
      csum         <= csum_n;
      err_checksum <= ec_n;
`endif
    end
  end
  pixel_fifo #(.DEPTH(FIFO_DEPTH), .T(pixel_beat_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (beat),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_spi_frame_parser.sv
// tb_spi_frame_parser: randomized frames checked every cycle against a byte-count/queue model of the parser
module tb_spi_frame_parser;
  import dither_pkg::*;
  logic clk = 0, rst = 0, byte_valid = 0, cs_active = 0, pix_ready = 0;
  logic [7:0] byte_data = 0;
  logic pix_valid, pix_eol, pix_eof, frame_busy, err_header, err_overflow, err_trunc;
  logic [7:0] pix_data;
  logic [15:0] pix_x, pix_y;
`ifdef SPI_FRAME_CHECKSUM_EN
  logic err_checksum;
`endif
  spi_frame_parser dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data), .cs_active(cs_active),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_eol(pix_eol), .pix_eof(pix_eof), .frame_busy(frame_busy), .err_header(err_header),
    .err_overflow(err_overflow),
`ifdef SPI_FRAME_CHECKSUM_EN
    .err_checksum(err_checksum),
`endif
    .err_trunc(err_trunc));
  always #5 clk = ~clk;
  int checks = 0, failures = 0, rdy_mode = 0;
  bit chk_en = 0;
  pixel_beat_t q[$], log_q[$];
  bit m_idle = 1, m_errmode = 0, popped;
  int nb = 0, mw = 0, mh = 0, pcnt = 0;
  logic [7:0] hdr [5];
  logic [7:0] m_x = 0;
  logic m_eh = 0, m_eo = 0, m_et = 0, m_ec = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: frame position is a byte count, pixel position an index; FIFO is a bounded queue
  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      m_idle = 1; m_errmode = 0; nb = 0; pcnt = 0; m_x = 0;
      m_eh = 0; m_eo = 0; m_et = 0; m_ec = 0;
    end else begin
      automatic pixel_beat_t b = '0;
      automatic bit do_push = 0;
      popped = q.size() != 0 && pix_ready;
      if (m_idle) begin
        if (byte_valid && cs_active) begin
          m_idle = 0;
          if (byte_data == 8'hA5) begin
            nb = 1; pcnt = 0; m_x = 0; m_eh = 0; m_eo = 0; m_et = 0; m_ec = 0;
          end else begin
            m_eh = 1; m_errmode = 1;
          end
        end
      end else if (m_errmode) begin
        if (!cs_active) begin m_idle = 1; m_errmode = 0; end
      end else if (!cs_active) begin
        m_et = 1; m_idle = 1;
      end else if (byte_valid) begin
        if (nb < 5) begin
          hdr[nb] = byte_data;
          nb++;
          if (nb == 5) begin
            mw = {hdr[1], hdr[2]};
            mh = {hdr[3], hdr[4]};
            if (mw == 0 || mw > 640 || mh == 0 || mh > 480) begin m_eh = 1; m_errmode = 1; end
          end
        end else if (nb == 5) begin
          b.data = byte_data;
          b.x = 16'(pcnt % mw);
          b.y = 16'(pcnt / mw);
          b.eol = (pcnt % mw) == mw - 1;
          b.eof = pcnt == mw * mh - 1;
          if (q.size() < 16 || popped) do_push = 1; else m_eo = 1;
          m_x ^= byte_data;
          pcnt++;
          if (pcnt == mw * mh) begin
`ifdef SPI_FRAME_CHECKSUM_EN
            nb = 6;
`else
            m_idle = 1;
`endif
          end
        end else begin
          if (byte_data != m_x) m_ec = 1;
          m_idle = 1;
        end
      end
      if (popped) void'(q.pop_front());
      if (do_push) q.push_back(b);
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pix_valid", pix_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("pix_data", pix_data, q[0].data);
        chk("pix_x", pix_x, q[0].x);
        chk("pix_y", pix_y, q[0].y);
        chk("pix_eol", pix_eol, q[0].eol);
        chk("pix_eof", pix_eof, q[0].eof);
        if (pix_ready) log_q.push_back(q[0]);
      end
      chk("frame_busy", frame_busy, !m_idle);
      chk("err_header", err_header, m_eh);
      chk("err_overflow", err_overflow, m_eo);
      chk("err_trunc", err_trunc, m_et);
`ifdef SPI_FRAME_CHECKSUM_EN
      chk("err_checksum", err_checksum, m_ec);
`endif
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
    byte_valid = 0;
    pix_ready = rdy_mode == 2 ? 1'($urandom % 2) : rdy_mode == 0;
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    byte_valid = 1;
    byte_data = b;
    step();
    repeat ($urandom_range(0, gap)) step();
  endtask
  task automatic start_frame(input logic [15:0] w, input logic [15:0] h, input int gap);
    cs_active = 1;
    step();
    send(8'hA5, gap); send(w[15:8], gap); send(w[7:0], gap); send(h[15:8], gap); send(h[7:0], gap);
  endtask
  task automatic pixels(input int n, input int gap);
    repeat (n) send(8'($urandom), gap);
  endtask
  task automatic end_cs();
    cs_active = 0;
    step();
    step();
  endtask
  task automatic drain();
    rdy_mode = 0;
    repeat (40) step();
    chk("drain_empty", pix_valid, 0);
  endtask
  initial begin
    rst = 0;
    step();
    chk_en = 1;
    step();
    rst = 1;
    chk("rst_valid", pix_valid, 0);
    chk("rst_busy", frame_busy, 0);
    chk("rst_errs", {err_header, err_overflow, err_trunc}, 0);
    // frame 4x2 with ready high
    rdy_mode = 0; step(); log_q.delete();
    start_frame(4, 2, 0); pixels(8, 0); end_cs(); drain();
    chk("t1_count", log_q.size(), 8);
    if (log_q.size() == 8) begin
      chk("t1_b3", {log_q[3].x, log_q[3].y, log_q[3].eol, log_q[3].eof}, {16'd3, 16'd0, 2'b10});
      chk("t1_b4", {log_q[4].x, log_q[4].y, log_q[4].eol, log_q[4].eof}, {16'd0, 16'd1, 2'b00});
      chk("t1_b7", {log_q[7].x, log_q[7].y, log_q[7].eol, log_q[7].eof}, {16'd3, 16'd1, 2'b11});
    end
    // overflow: 20 pixels into 16 entries with ready low
    rdy_mode = 1; step();
    start_frame(20, 1, 1); pixels(20, 1); end_cs();
    chk("t2_overflow", err_overflow, 1);
    chk("t2_head_x", pix_x, 0);
    chk("t2_head_valid", pix_valid, 1);
    log_q.delete(); drain();
    chk("t2_count", log_q.size(), 16);
    if (log_q.size() == 16) chk("t2_last_x", log_q[15].x, 15);
    // bad sync then a good frame
    cs_active = 1; step();
    send(8'h3C, 0);
    chk("t3_err_header", err_header, 1);
    send(8'hA5, 0); send(8'h00, 0); send(8'h04, 0);
    chk("t3_busy_err", frame_busy, 1);
    end_cs();
    chk("t3_idle", frame_busy, 0);
    rdy_mode = 2;
    start_frame(4, 2, 2); pixels(8, 2); end_cs(); drain();
    chk("t3_cleared", err_header, 0);
    // header bounds
    start_frame(0, 2, 0);
    chk("t4_w0", {err_header, frame_busy}, 2'b11);
    pixels(3, 0);
    chk("t4_w0_novalid", pix_valid, 0);
    end_cs();
    start_frame(641, 1, 0);
    chk("t4_w641", err_header, 1);
    end_cs();
    start_frame(640, 481, 0);
    chk("t4_h481", err_header, 1);
    end_cs();
    start_frame(640, 480, 0);
    chk("t4_max_ok", {err_header, frame_busy}, 2'b01);
    pixels(2, 0); end_cs(); drain();
    // truncation after 3 of 8 pixels
    rdy_mode = 1; step();
    start_frame(4, 2, 0); pixels(3, 0); end_cs();
    chk("t5_trunc", {err_trunc, frame_busy}, 2'b10);
    log_q.delete(); drain();
    chk("t5_count", log_q.size(), 3);
    if (log_q.size() == 3) chk("t5_no_eof", log_q[2].eof, 0);
    // reset mid-frame with a full FIFO and a sticky error
    rdy_mode = 1; step();
    start_frame(20, 1, 0); pixels(18, 0);
    chk("t6_pre_overflow", err_overflow, 1);
    rst = 0; cs_active = 0;
    step();
    chk("t6_valid", pix_valid, 0);
    chk("t6_busy", frame_busy, 0);
    chk("t6_errs", {err_header, err_overflow, err_trunc}, 0);
    rst = 1; step();
`ifdef SPI_FRAME_CHECKSUM_EN
    rdy_mode = 0;
    start_frame(4, 1, 0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0); send(8'h04, 0);
    chk("t7_ok", err_checksum, 0);
    end_cs();
    start_frame(4, 1, 0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0); send(8'h05, 0);
    chk("t7_bad", err_checksum, 1);
    end_cs(); drain();
`endif
    // random frames, random ready, occasional truncation
    for (int f = 0; f < 40; f++) begin
      automatic int w = $urandom_range(1, 8);
      automatic int h = $urandom_range(1, 4);
      automatic int n = ($urandom % 4 == 0) ? $urandom_range(0, w * h - 1) : w * h;
      rdy_mode = 2;
      start_frame(16'(w), 16'(h), 2);
      pixels(n, 2);
`ifdef SPI_FRAME_CHECKSUM_EN
      if (n == w * h) send(8'($urandom), 1);
`endif
      end_cs();
      repeat ($urandom_range(0, 5)) step();
    end
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
